// File: rtl/cordic_arbiter_pkg.sv
// Shared types and constants for the CORDIC arbiter slice.
package cordic_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP
  } state_e;

  localparam int DEF_TIMEOUT = 64;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cordic_arbiter_rr_priority.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_priority
  import cordic_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDW   = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   grant_idx,
  output logic             any
);

  logic [IDW:0] sum;

  // Wrap by compare-and-subtract so non power-of-two N_REQ stays in range.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    sum       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(N_REQ)) sum = sum - (IDW+1)'(N_REQ);
      if (!any && req[sum[IDW-1:0]]) begin
        any                    = 1'b1;
        grant[sum[IDW-1:0]]    = 1'b1;
        grant_idx              = sum[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one iterative CORDIC core among N_REQ requesters, one operation in flight,
// with round-robin grant, single-pulse start, watchdog abort and per-requester response.
module cordic_arbiter
  import cordic_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int BIT_WIDTH = 16,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*BIT_WIDTH-1:0] req_operand,
  output logic [N_REQ-1:0]           req_ready,
  output logic [N_REQ-1:0]           rsp_valid,
  input  logic [N_REQ-1:0]           rsp_ready,
  output logic [BIT_WIDTH-1:0]       rsp_x,
  output logic [BIT_WIDTH-1:0]       rsp_y,
  output logic                       rsp_err,
  output logic                       busy,
  output logic                       core_start,
  output logic [BIT_WIDTH-1:0]       core_operand,
  input  logic                       core_done,
  input  logic [BIT_WIDTH-1:0]       core_x,
  input  logic [BIT_WIDTH-1:0]       core_y
);

  localparam int             IDW     = id_w(N_REQ);
  localparam int             WDW     = $clog2(TIMEOUT) + 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0] WD_MAX  = '1;

  state_e                         state_q, state_d;
  logic [IDW-1:0]                 ptr_q, ptr_d, id_q, id_d;
  logic [WDW-1:0]                 wd_q, wd_d;
  logic [BIT_WIDTH-1:0]           op_q, op_d, x_q, x_d, y_q, y_d;
  logic                           err_q, err_d, start_q, start_d, busy_q, busy_d;
  logic [N_REQ-1:0]               rv_q, rv_d;

  logic [N_REQ-1:0]               pick;
  logic [IDW-1:0]                 pick_idx;
  logic                           pick_any;
  logic                           grant_ok;
  logic [N_REQ-1:0][BIT_WIDTH-1:0] opnd;

  assign opnd = req_operand;

  rr_priority #(.N_REQ(N_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (pick),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  // Reset gates the combinational accept so nothing is taken while held in reset.
  assign grant_ok  = reset && (state_q == S_IDLE) && pick_any && core_done;
  assign req_ready = grant_ok ? pick : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    wd_d    = wd_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    err_d   = err_q;
    rv_d    = rv_q;
    start_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (grant_ok) begin
          op_d    = opnd[pick_idx];
          id_d    = pick_idx;
          start_d = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wd_q != WD_MAX) wd_d = wd_q + 1'b1;
        // A done on the last watchdog cycle still counts as a real result.
        if (core_done) begin
          x_d     = core_x;
          y_d     = core_y;
          err_d   = 1'b0;
          rv_d    = N_REQ'(1) << id_q;
          state_d = S_RESP;
        end else if (wd_q == WD_LAST) begin
          x_d     = '0;
          y_d     = '0;
          err_d   = 1'b1;
          rv_d    = N_REQ'(1) << id_q;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready[id_q]) begin
          rv_d    = '0;
          ptr_d   = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      wd_q    <= '0;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      rv_q    <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      wd_q    <= wd_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      err_q   <= err_d;
      rv_q    <= rv_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign rsp_valid    = rv_q;
  assign rsp_x        = x_q;
  assign rsp_y        = y_q;
  assign rsp_err      = err_q;
  assign busy         = busy_q;
  assign core_start   = start_q;
  assign core_operand = op_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Scoreboard bench for cordic_arbiter: expected grants/responses queued at issue time,
// independent monitors pop and compare on core_start and on response handshakes.
module tb_cordic_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_operand = '0;
  logic [N-1:0]   req_ready, rsp_valid;
  logic [N-1:0]   rsp_ready = '1;
  logic [W-1:0]   rsp_x, rsp_y, core_operand, core_x, core_y;
  logic           rsp_err, busy, core_start, core_done;

  int vectors = 0;
  int errs    = 0;

  typedef struct { int id; logic [W-1:0] op; } gexp_t;
  typedef struct { int id; logic [W-1:0] x; logic [W-1:0] y; logic err; } rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];

  int           left[N] = '{default: 0};
  logic [W-1:0] nxt_op[N];
  int           core_lat = 5;
  logic [W-1:0] core_xk = 16'h1111;
  logic [W-1:0] core_yk = 16'h2222;

  always #5 clk = ~clk;

  cordic_arbiter #(.N_REQ(N), .BIT_WIDTH(W), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_operand(req_operand), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_err(rsp_err), .busy(busy),
    .core_start(core_start), .core_operand(core_operand),
    .core_done(core_done), .core_x(core_x), .core_y(core_y)
  );

  // Core model: done drops on start, rises core_lat cycles later with operand^key.
  logic [W-1:0] c_op;
  int           c_cnt;
  always @(posedge clk) begin
    if (!reset) begin
      core_done <= 1'b1; c_cnt <= 0; core_x <= '0; core_y <= '0; c_op <= '0;
    end else if (core_start) begin
      core_done <= 1'b0; c_cnt <= core_lat; c_op <= core_operand;
    end else if (c_cnt == 1) begin
      core_done <= 1'b1; c_cnt <= 0;
      core_x <= c_op ^ core_xk; core_y <= c_op ^ core_yk;
    end else if (c_cnt > 1) begin
      c_cnt <= c_cnt - 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic issue(input int i, input logic [W-1:0] op, input int n);
    left[i] = n; nxt_op[i] = op;
    req_valid[i] = 1'b1; req_operand[i*W +: W] = op;
  endtask

  task automatic exp_g(input int id, input logic [W-1:0] op);
    gexp_t e; e.id = id; e.op = op; gq.push_back(e);
  endtask

  task automatic exp_r(input int id, input logic [W-1:0] x, input logic [W-1:0] y, input logic er);
    rexp_t e; e.id = id; e.x = x; e.y = y; e.err = er; rq.push_back(e);
  endtask

  task automatic measure(input string nm, input int exp);
    int n = 0;
    while (!core_start && n < 50) begin @(negedge clk); n++; end
    chk({nm, "_start"}, 64'(core_start), 64'd1);
    n = 0;
    while (rsp_valid == '0 && n < 300) begin @(negedge clk); n++; end
    chk({nm, "_latency"}, 64'(n), 64'(exp));
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (!(busy == 1'b0 && req_valid == '0 && rq.size() == 0 && gq.size() == 0) && n < 3000) begin
      @(negedge clk); n++;
    end
    chk({nm, "_drain"}, 64'(n < 3000), 64'd1);
  endtask

  task automatic pulse_reset();
    sync(); reset = 1'b0;
    sync(); reset = 1'b1;
    @(negedge clk);
  endtask

  // Requester model: hold valid until accepted, then move to the next operand.
  initial begin : req_drv
    logic [N-1:0] snap;
    forever begin
      @(negedge clk); snap = req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (snap[i]) begin left[i]--; nxt_op[i] = nxt_op[i] + 1'b1; end
        req_valid[i] = (left[i] > 0);
        req_operand[i*W +: W] = nxt_op[i];
      end
    end
  end

  initial begin : gmon
    gexp_t e;
    int    lg;
    lg = -1;
    forever begin
      @(negedge clk);
      if (req_ready != '0) begin
        chk("req_ready_onehot", 64'($onehot(req_ready)), 64'd1);
        lg = idx_of(req_ready);
      end
      if (core_start) begin
        if (gq.size() == 0) chk("unexpected_start", 64'd1, 64'd0);
        else begin
          e = gq.pop_front();
          chk("grant_id", 64'(lg), 64'(e.id));
          chk("core_operand", 64'(core_operand), 64'(e.op));
        end
      end
    end
  end

  initial begin : rmon
    rexp_t e;
    forever begin
      @(negedge clk);
      if ((rsp_valid & rsp_ready) != '0) begin
        if (rq.size() == 0) chk("unexpected_rsp", 64'd1, 64'd0);
        else begin
          e = rq.pop_front();
          chk("rsp_onehot", 64'($onehot(rsp_valid)), 64'd1);
          chk("rsp_id", 64'(idx_of(rsp_valid)), 64'(e.id));
          chk("rsp_x", 64'(rsp_x), 64'(e.x));
          chk("rsp_y", 64'(rsp_y), 64'(e.y));
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
        end
      end
    end
  end

  initial begin : main
    logic [W-1:0] x0, y0;
    logic [W-1:0] op;

    // Reset held with every requester pending.
    for (int i = 0; i < N; i++) begin
      op = 16'((i + 1) * 256);
      issue(i, op, 1);
      exp_g(i, op);
      exp_r(i, op ^ 16'h1111, op ^ 16'h2222, 1'b0);
    end
    repeat (3) begin
      @(negedge clk);
      chk("rst_ctl", 64'({req_ready, rsp_valid, core_start, busy, rsp_err}), 64'd0);
      chk("rst_data", 64'({rsp_x, rsp_y, core_operand}), 64'd0);
    end
    sync(); reset = 1'b1;
    @(negedge clk);
    chk("rst_first_grant", 64'(req_ready), 64'h1);
    wait_idle("t1");

    // Fairness: everyone pending for two rounds.
    sync();
    for (int i = 0; i < N; i++) issue(i, 16'(32'h1000 * (i + 1)), 2);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) begin
        op = 16'(32'h1000 * (i + 1) + r);
        exp_g(i, op);
        exp_r(i, op ^ core_xk, op ^ core_yk, 1'b0);
      end
    wait_idle("t3");

    // Single request with hand-computed result.
    core_xk = 16'h1834; core_yk = 16'h1934;
    sync();
    issue(2, 16'h1234, 1);
    exp_g(2, 16'h1234);
    exp_r(2, 16'h0A00, 16'h0B00, 1'b0);
    measure("t2", 7);
    wait_idle("t2");

    // Backpressure on requester 1 with requester 3 waiting behind it.
    sync();
    rsp_ready[1] = 1'b0;
    issue(1, 16'h4321, 1);
    exp_g(1, 16'h4321);
    exp_r(1, 16'h5B15, 16'h5A15, 1'b0);
    measure("t4", 7);
    sync();
    issue(3, 16'h5555, 1);
    exp_g(3, 16'h5555);
    exp_r(3, 16'h4D61, 16'h4C61, 1'b0);
    x0 = rsp_x; y0 = rsp_y;
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold", 64'({rsp_valid, rsp_x, rsp_y, core_start, req_ready}),
          64'({4'b0010, x0, y0, 1'b0, 4'b0000}));
    end
    sync(); rsp_ready[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_resume_grant", 64'(req_ready), 64'h8);
    wait_idle("t4");

    // Timeout, normal recovery, then done on the final watchdog cycle.
    core_lat = 64;
    sync();
    issue(0, 16'h0777, 1);
    exp_g(0, 16'h0777);
    exp_r(0, 16'h0000, 16'h0000, 1'b1);
    measure("t5_timeout", 65);
    wait_idle("t5a");
    core_lat = 5;
    sync();
    issue(1, 16'h0888, 1);
    exp_g(1, 16'h0888);
    exp_r(1, 16'h10BC, 16'h11BC, 1'b0);
    wait_idle("t5b");
    core_lat = 63;
    sync();
    issue(2, 16'h0999, 1);
    exp_g(2, 16'h0999);
    exp_r(2, 16'h11AD, 16'h10AD, 1'b0);
    measure("t5_coincide", 65);
    wait_idle("t5c");

    // Reset in S_WAIT: op discarded, pointer back to 0 (requests 1 and 3 -> 1 first).
    core_lat = 64;
    sync();
    issue(3, 16'h0AAA, 1);
    exp_g(3, 16'h0AAA);
    repeat (8) @(negedge clk);
    pulse_reset();
    chk("rst_wait_state", 64'({busy, rsp_valid, core_start}), 64'd0);
    core_lat = 5;
    sync();
    issue(1, 16'h0B0B, 1);
    issue(3, 16'h0C0C, 1);
    exp_g(1, 16'h0B0B); exp_r(1, 16'h133F, 16'h123F, 1'b0);
    exp_g(3, 16'h0C0C); exp_r(3, 16'h1438, 16'h1538, 1'b0);
    @(negedge clk);
    chk("rst_wait_ptr", 64'(req_ready), 64'h2);
    wait_idle("t6a");

    // Reset in S_RESP: pending response dropped, pointer back to 0.
    sync();
    issue(1, 16'h0D0D, 1);
    exp_g(1, 16'h0D0D); exp_r(1, 16'h1539, 16'h1439, 1'b0);
    wait_idle("t6b");
    sync();
    rsp_ready[2] = 1'b0;
    issue(2, 16'h0E0E, 1);
    exp_g(2, 16'h0E0E);
    measure("t6_resp", 7);
    pulse_reset();
    chk("rst_resp_state", 64'({busy, rsp_valid}), 64'd0);
    sync();
    rsp_ready = '1;
    issue(1, 16'h0F0F, 1);
    issue(3, 16'h0101, 1);
    exp_g(1, 16'h0F0F); exp_r(1, 16'h173B, 16'h163B, 1'b0);
    exp_g(3, 16'h0101); exp_r(3, 16'h1935, 16'h1835, 1'b0);
    @(negedge clk);
    chk("rst_resp_ptr", 64'(req_ready), 64'h2);
    wait_idle("t6c");

    chk("grant_queue_empty", 64'(gq.size()), 64'd0);
    chk("rsp_queue_empty", 64'(rq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin : guard
    #400000;
    errs++;
    $display("FAIL global_timeout: got no finish expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $fatal(1);
  end

endmodule
